instr_mem_loader: RTL

Writable 16-entry instruction memory with a byte-stream write port, the loading counterpart of the datapath's fixed instruction ROM. A host streams bytes over a valid/ready handshake; the block assembles them big-endian into 16-bit instructions, writes them sequentially from address 0, and holds the core stalled until all entries are loaded. The read port keeps the ROM's combinational address-to-instruction behaviour, so the datapath fetch path is unchanged.

---
 rtl/instr_mem_loader_pkg.sv | 17 +
 rtl/instr_mem_loader_ram.sv | 33 +++
 rtl/instr_mem_loader.sv | 119 +++++++++++
 3 files changed

// File: rtl/instr_mem_loader_pkg.sv
// Shared types and constants for the loadable instruction memory.
package instr_mem_loader_pkg;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] RESET_WORD = 16'h0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GET_HI = 2'd1,
    GET_LO = 2'd2,
    DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/instr_mem_loader_ram.sv
// DEPTH x DATA_W register array: one synchronous write port, one combinational read port.
module instr_mem_loader_ram
  import instr_mem_loader_pkg::*;
#(
  parameter int DEPTH  = instr_mem_loader_pkg::DEPTH,
  parameter int ADDR_W = instr_mem_loader_pkg::ADDR_W,
  parameter int DATA_W = instr_mem_loader_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Reset clears the whole array so a half-loaded program never survives rst_n.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= RESET_WORD;
      end
    end else if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the instruction memory: assembles big-endian words,
// writes them from address 0 upward and stalls the core until DEPTH words land.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int DEPTH  = instr_mem_loader_pkg::DEPTH,
  parameter int ADDR_W = instr_mem_loader_pkg::ADDR_W,
  parameter int DATA_W = instr_mem_loader_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_instr,
  output logic              cpu_hold,
  output logic              load_done,
  output logic [ADDR_W:0]   word_count,
  output logic [7:0]        checksum
);

  state_e            state_q, state_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic [7:0]        cs_q, cs_d;
  logic              in_ready_q, in_ready_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              load_done_q, load_done_d;
  logic              we;
  logic              accept;

  assign accept = in_valid & in_ready_q;

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    ptr_d   = ptr_q;
    wc_d    = wc_q;
    cs_d    = cs_q;
    we      = 1'b0;
    // load_start wins over a byte accepted on the same edge.
    if (load_start) begin
      state_d = GET_HI;
      hi_d    = 8'h00;
      ptr_d   = '0;
      wc_d    = '0;
      cs_d    = 8'h00;
    end else begin
      case (state_q)
        GET_HI: begin
          if (accept) begin
            hi_d    = in_byte;
            cs_d    = cs_q + in_byte;
            state_d = GET_LO;
          end
        end
        GET_LO: begin
          if (accept) begin
            we      = 1'b1;
            cs_d    = cs_q + in_byte;
            ptr_d   = ptr_q + ADDR_W'(1);
            wc_d    = wc_q + (ADDR_W+1)'(1);
            state_d = (wc_q == (ADDR_W+1)'(DEPTH-1)) ? DONE : GET_HI;
          end
        end
        default: ;
      endcase
    end
    in_ready_d  = (state_d == GET_HI) || (state_d == GET_LO);
    cpu_hold_d  = in_ready_d;
    load_done_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hi_q        <= 8'h00;
      ptr_q       <= '0;
      wc_q        <= '0;
      cs_q        <= 8'h00;
      in_ready_q  <= 1'b0;
      cpu_hold_q  <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hi_q        <= hi_d;
      ptr_q       <= ptr_d;
      wc_q        <= wc_d;
      cs_q        <= cs_d;
      in_ready_q  <= in_ready_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
    end
  end

  instr_mem_loader_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .waddr   (ptr_q),
    .wdata   ({hi_q, in_byte}),
    .rd_addr (rd_addr),
    .rd_data (rd_instr)
  );

  assign in_ready   = in_ready_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign word_count = wc_q;
  assign checksum   = cs_q;

endmodule
